lsu_dmem: RTL and testbench

- Load/store unit directly downstream of the ALU stage.
- Consumes the ALU's effective address (alu_out), store data (rb), funct3 and load/store intent.
- Performs byte-lane alignment and misalignment checks, drives a single-port word-addressed data memory over a req/ack handshake, and returns sign- or zero-extended load data to writeback.
- Replaces the ALU's internal r_temp scratch storage with a real memory path.

---
 rtl/lsu_pkg.sv | 51 +++++
 rtl/lsu_lane_align.sv | 77 +++++++
 rtl/lsu_dmem.sv | 170 +++++++++++++++++
 tb/tb_lsu_dmem.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the FSM state encoding, the RV32I funct3 width/sign codes for loads
// and stores (same values the ALU uses), the access-width codes and the
// load-data extraction helper used when a read word comes back from memory.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_width_e;

    localparam logic [2:0] FUNC_LB  = 3'b000;
    localparam logic [2:0] FUNC_LH  = 3'b001;
    localparam logic [2:0] FUNC_LW  = 3'b010;
    localparam logic [2:0] FUNC_LBU = 3'b100;
    localparam logic [2:0] FUNC_LHU = 3'b101;

    localparam logic [2:0] FUNC_SB  = 3'b000;
    localparam logic [2:0] FUNC_SH  = 3'b001;
    localparam logic [2:0] FUNC_SW  = 3'b010;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        shifted = word >> {addr_lo, 3'b000};
        b       = shifted[7:0];
        h       = addr_lo[1] ? word[31:16] : word[15:0];
        case (f3)
            FUNC_LB:  res = {{24{b[7]}}, b};
            FUNC_LH:  res = {{16{h[15]}}, h};
            FUNC_LW:  res = word;
            FUNC_LBU: res = {24'd0, b};
            FUNC_LHU: res = {16'd0, h};
            default:  res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the load/store unit.
// Ports:
//   is_store  - 1 = store, 0 = load (selects the legal funct3 set)
//   funct3    - RV32I width/sign code
//   addr_lo   - byte offset within the word (addr[1:0])
//   wdata     - raw store data
//   be        - byte enables for the access
//   wdata_sh  - store data replicated onto every lane it could land in
//   legal     - funct3 is a defined code for this direction
//   aligned   - address offset is a multiple of the access size
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic        legal,
    output logic        aligned
);

    lsu_width_e width_s;

    // Decode width and legality, then derive enables, lane data and alignment.
    always_comb begin
        width_s  = WORD;
        legal    = 1'b0;
        aligned  = 1'b0;
        be       = 4'b0000;
        wdata_sh = wdata;

        case (funct3[1:0])
            2'b00:   width_s = BYTE;
            2'b01:   width_s = HALF;
            default: width_s = WORD;
        endcase

        if (is_store) begin
            case (funct3)
                FUNC_SB, FUNC_SH, FUNC_SW: legal = 1'b1;
                default:                   legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                FUNC_LB, FUNC_LH, FUNC_LW, FUNC_LBU, FUNC_LHU: legal = 1'b1;
                default:                                       legal = 1'b0;
            endcase
        end

        // Replicating the data means the memory only needs the enables to pick lanes.
        case (width_s)
            BYTE: begin
                aligned  = 1'b1;
                be       = 4'b0001 << addr_lo;
                wdata_sh = {4{wdata[7:0]}};
            end
            HALF: begin
                aligned  = ~addr_lo[0];
                be       = 4'b0011 << addr_lo;
                wdata_sh = {2{wdata[15:0]}};
            end
            WORD: begin
                aligned  = (addr_lo == 2'b00);
                be       = 4'b1111;
                wdata_sh = wdata;
            end
            default: begin
                aligned  = 1'b0;
                be       = 4'b0000;
                wdata_sh = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit sitting after the ALU stage.
// Accepts one request at a time (start_i while ready_o), checks legality and
// alignment, runs a req/ack access to a word-addressed data memory, and
// returns extended load data with a one-cycle done_o/err_o pulse.
// Ports:
//   start_i/is_store_i/funct3_i/addr_i/wdata_i - request from the ALU stage
//   ready_o, done_o, err_o, rdata_o            - status and load result
//   mem_req_o .. mem_wdata_o, mem_ack_i, mem_rdata_i - data memory handshake
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    // Counter value on the last cycle req may wait for an ack.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    lsu_state_e        state_r;
    logic [7:0]        cnt_r;
    logic              is_store_r;
    logic [2:0]        funct3_r;
    logic [1:0]        addr_lo_r;
    logic              ready_r;
    logic              done_r;
    logic              err_r;
    logic [31:0]       rdata_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [3:0]        mem_be_r;
    logic [31:0]       mem_wdata_r;

    logic [3:0]        be_s;
    logic [31:0]       wdata_sh_s;
    logic              legal_s;
    logic              aligned_s;
    logic              unused_s;

    // Address bits above the memory window do not take part in the access.
    assign unused_s = ^{addr_i[31:ADDR_W+2], 1'b0};

    lsu_lane_align u_align (
        .is_store (is_store_i),
        .funct3   (funct3_i),
        .addr_lo  (addr_i[1:0]),
        .wdata    (wdata_i),
        .be       (be_s),
        .wdata_sh (wdata_sh_s),
        .legal    (legal_s),
        .aligned  (aligned_s)
    );

    // Request FSM, timeout counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            is_store_r  <= 1'b0;
            funct3_r    <= 3'b000;
            addr_lo_r   <= 2'b00;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= 32'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (start_i) begin
                        is_store_r  <= is_store_i;
                        funct3_r    <= funct3_i;
                        addr_lo_r   <= addr_i[1:0];
                        mem_addr_r  <= addr_i[ADDR_W+1:2];
                        mem_be_r    <= be_s;
                        mem_wdata_r <= wdata_sh_s;
                        ready_r     <= 1'b0;
                        cnt_r       <= 8'd0;
                        if (legal_s && aligned_s) begin
                            state_r   <= ST_ACCESS;
                            mem_req_r <= 1'b1;
                            mem_we_r  <= is_store_i;
                        end else begin
                            // Bad requests never reach memory; report straight away.
                            state_r <= ST_RESP;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack_i) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        cnt_r     <= 8'd0;
                        if (!is_store_r) begin
                            rdata_r <= load_extract(funct3_r, addr_lo_r, mem_rdata_i);
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        done_r  <= 1'b1;
                        err_r   <= 1'b0;
                        state_r <= ST_RESP;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        cnt_r     <= 8'd0;
                        done_r    <= 1'b1;
                        err_r     <= 1'b1;
                        state_r   <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r    <= 1'b0;
                    err_r     <= 1'b0;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    ready_r   <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o     = ready_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign rdata_o     = rdata_r;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_be_o    = mem_be_r;
    assign mem_wdata_o = mem_wdata_r;

endmodule

// File: tb/tb_lsu_dmem.sv
// Self-checking bench for lsu_dmem: directed vector table, hand-written
// multi-cycle sequences and randomized accesses against a behavioural model.
module tb_lsu_dmem;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [4:0]  mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_err    = 0;

    lsu_dmem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .is_store_i  (is_store_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .ready_o     (ready_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_after;   // req cycle on which ack is given; 0 = never
        logic [31:0] rword;
        logic        exp_err;
        int          exp_lat;     // cycles from the start edge to done
        int          exp_req;     // number of cycles req is seen high
        logic [4:0]  exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    // Results of the most recent access.
    int          g_lat;
    int          g_reqcyc;
    logic        g_err;
    logic [31:0] g_rdata;
    logic [4:0]  g_maddr;
    logic [3:0]  g_be;
    logic        g_we;
    logic [31:0] g_wdata;
    logic        g_unstable;
    logic        g_spurious;
    logic        g_ready_busy;
    logic        g_ready_after;
    logic        g_done_after;

    logic [31:0] exp_rd;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Issue one request and play the memory side until done_o (bounded).
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] ad,
                           input logic [31:0] wd, input int ack_after, input logic [31:0] rw);
        int k;
        @(negedge clk);
        start_i     = 1'b1;
        is_store_i  = st;
        funct3_i    = f3;
        addr_i      = ad;
        wdata_i     = wd;
        mem_rdata_i = rw;
        mem_ack_i   = 1'b0;
        g_lat = -1; g_reqcyc = 0; g_err = 1'bx; g_rdata = 32'hx;
        g_maddr = 5'd0; g_be = 4'd0; g_we = 1'b0; g_wdata = 32'd0;
        g_unstable = 1'b0; g_spurious = 1'b0; g_ready_busy = 1'b1;
        g_ready_after = 1'b0; g_done_after = 1'b1;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start_i   = 1'b0;
            mem_ack_i = 1'b0;
            if (i == 1) g_ready_busy = ready_o;
            if (err_o && !done_o) g_spurious = 1'b1;
            if (mem_req_o) begin
                k++;
                if (k == 1) begin
                    g_maddr = mem_addr_o; g_be = mem_be_o; g_we = mem_we_o; g_wdata = mem_wdata_o;
                end else if (mem_addr_o !== g_maddr || mem_be_o !== g_be ||
                             mem_we_o !== g_we || mem_wdata_o !== g_wdata) begin
                    g_unstable = 1'b1;
                end
                if (k == ack_after) mem_ack_i = 1'b1;
            end
            if (done_o) begin
                g_lat   = i;
                g_err   = err_o;
                g_rdata = rdata_o;
                break;
            end
        end
        g_reqcyc = k;
        mem_ack_i = 1'b0;
        @(negedge clk);
        g_ready_after = ready_o;
        g_done_after  = done_o;
    endtask

    task automatic apply(input vec_t v, input string tag);
        run_req(v.st, v.f3, v.addr, v.wdata, v.ack_after, v.rword);
        chk({tag, " latency"}, g_lat, v.exp_lat);
        chk({tag, " err"}, {31'd0, g_err}, {31'd0, v.exp_err});
        chk({tag, " rdata"}, g_rdata, v.exp_rdata);
        chk({tag, " req_cycles"}, g_reqcyc, v.exp_req);
        chk({tag, " ready_busy"}, {31'd0, g_ready_busy}, 32'd0);
        chk({tag, " ready_after"}, {31'd0, g_ready_after}, 32'd1);
        chk({tag, " done_one_cycle"}, {31'd0, g_done_after}, 32'd0);
        chk({tag, " err_without_done"}, {31'd0, g_spurious}, 32'd0);
        chk({tag, " req_stable"}, {31'd0, g_unstable}, 32'd0);
        if (v.exp_req > 0) begin
            chk({tag, " mem_addr"}, {27'd0, g_maddr}, {27'd0, v.exp_maddr});
            chk({tag, " mem_be"}, {28'd0, g_be}, {28'd0, v.exp_be});
            chk({tag, " mem_we"}, {31'd0, g_we}, {31'd0, v.st});
            if (v.st) chk({tag, " mem_wdata"}, g_wdata, v.exp_wdata);
        end
        exp_rd = v.exp_rdata;
    endtask

    // Reference model: derives everything from sizes and byte offsets.
    function automatic vec_t model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wd, input int ack_after,
                                   input logic [31:0] rw, input logic [31:0] prev);
        vec_t   v;
        int     size_b;
        int     ofs;
        bit     legal;
        longint lv;
        longint bits;
        v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wd; v.ack_after = ack_after; v.rword = rw;
        legal  = st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size_b = 1 << (f3 % 4);
        ofs    = int'(addr % 32'd4);
        v.exp_maddr = 5'((addr / 32'd4) % 32'd32);
        v.exp_be    = (size_b == 4) ? 4'hF : 4'(((1 << size_b) - 1) << ofs);
        v.exp_wdata = (size_b == 1) ? wd[7:0] * 32'h0101_0101 :
                      (size_b == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        if (!legal || (addr % size_b) != 0) begin
            v.exp_err = 1'b1; v.exp_lat = 1; v.exp_req = 0; v.exp_rdata = prev;
        end else if (ack_after == 0) begin
            v.exp_err = 1'b1; v.exp_lat = 16; v.exp_req = 15; v.exp_rdata = prev;
        end else begin
            v.exp_err = 1'b0; v.exp_lat = 1 + ack_after; v.exp_req = ack_after;
            if (st) begin
                v.exp_rdata = prev;
            end else begin
                bits = 8 * size_b;
                lv   = longint'(rw) / (longint'(1) << (8 * ofs));
                lv   = lv % (longint'(1) << bits);
                if (f3[2] == 1'b0 && size_b < 4 && lv >= (longint'(1) << (bits - 1)))
                    lv = lv - (longint'(1) << bits);
                v.exp_rdata = lv[31:0];
            end
        end
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        int dones;
        int reqs;
        vec_t v;

        // st f3 addr wdata ack rword | err lat req maddr be wdata rdata
        vecs[0]  = '{1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 1, 32'h0,        1'b0, 2,  1,  5'd5, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h15, 32'h0,        1, 32'h00008000, 1'b0, 2,  1,  5'd5, 4'h2, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b0, 3'b100, 32'h15, 32'h0,        1, 32'h00008000, 1'b0, 2,  1,  5'd5, 4'h2, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b1, 3'b001, 32'h16, 32'h1234ABCD, 1, 32'h0,        1'b0, 2,  1,  5'd5, 4'hC, 32'hABCDABCD, 32'h00000080};
        vecs[4]  = '{1'b0, 3'b001, 32'h16, 32'h0,        1, 32'hABCD0000, 1'b0, 2,  1,  5'd5, 4'hC, 32'h0,        32'hFFFFABCD};
        vecs[5]  = '{1'b0, 3'b010, 32'h13, 32'h0,        1, 32'h0,        1'b1, 1,  0,  5'd0, 4'h0, 32'h0,        32'hFFFFABCD};
        vecs[6]  = '{1'b0, 3'b011, 32'h10, 32'h0,        1, 32'h0,        1'b1, 1,  0,  5'd0, 4'h0, 32'h0,        32'hFFFFABCD};
        vecs[7]  = '{1'b0, 3'b010, 32'h20, 32'h0,        0, 32'hFFFFFFFF, 1'b1, 16, 15, 5'd8, 4'hF, 32'h0,        32'hFFFFABCD};
        vecs[8]  = '{1'b0, 3'b010, 32'h24, 32'h0,        3, 32'h13579BDF, 1'b0, 4,  3,  5'd9, 4'hF, 32'h0,        32'h13579BDF};
        vecs[9]  = '{1'b1, 3'b000, 32'h03, 32'h000000A5, 1, 32'h0,        1'b0, 2,  1,  5'd0, 4'h8, 32'hA5A5A5A5, 32'h13579BDF};
        vecs[10] = '{1'b1, 3'b100, 32'h00, 32'h0,        1, 32'h0,        1'b1, 1,  0,  5'd0, 4'h0, 32'h0,        32'h13579BDF};
        vecs[11] = '{1'b0, 3'b101, 32'h02, 32'h0,        1, 32'h80010000, 1'b0, 2,  1,  5'd0, 4'hC, 32'h0,        32'h00008001};

        rst_n = 1'b0; start_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'd0;
        addr_i = 32'd0; wdata_i = 32'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        exp_rd = 32'd0;

        // Reset state.
        #12;
        chk("rst ready", {31'd0, ready_o}, 32'd1);
        chk("rst outs", {done_o, err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, 19'd0}, 32'd0);
        chk("rst rdata", rdata_o, 32'd0);
        chk("rst wdata", mem_wdata_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst ready", {31'd0, ready_o}, 32'd1);

        for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Start held high while busy: only the first request is taken.
        @(negedge clk);
        start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010;
        addr_i = 32'h8; wdata_i = 32'd0; mem_rdata_i = 32'h11223344;
        dones = 0; reqs = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            addr_i    = 32'h4 * 32'(i);
            mem_ack_i = 1'b0;
            if (mem_req_o) begin
                reqs++;
                if (reqs == 2) mem_ack_i = 1'b1;
                if (mem_addr_o !== 5'd2) begin
                    n_checks++; n_err++;
                    $display("FAIL busy mem_addr: got %h expected 02", mem_addr_o);
                end
            end
            if (done_o) begin
                dones++;
                start_i = 1'b0;
                chk("busy rdata", rdata_o, 32'h11223344);
            end
        end
        start_i = 1'b0;
        chk("busy dones", dones, 32'd1);
        chk("busy req_cycles", reqs, 32'd2);
        exp_rd = 32'h11223344;

        // Ack while idle has no effect.
        @(negedge clk);
        mem_ack_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle ack", {29'd0, done_o, mem_req_o, ready_o}, 32'd1);
        mem_ack_i = 1'b0;

        // Randomized accesses against the model.
        for (int n = 0; n < 40; n++) begin
            int aa;
            aa = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            v = model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      32'($urandom_range(0, 127)), $urandom, aa, $urandom, exp_rd);
            apply(v, $sformatf("rnd%0d", n));
        end

        // Reset during ACCESS: req drops at once, no done for the aborted access.
        @(negedge clk);
        start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h30;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("mid req_up", {31'd0, mem_req_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid req_drop", {31'd0, mem_req_o}, 32'd0);
        chk("mid ready", {31'd0, ready_o}, 32'd1);
        chk("mid rdata", rdata_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_o || mem_req_o) dones++;
        end
        chk("mid no_done", dones, 32'd0);
        exp_rd = 32'd0;
        v = model(1'b0, 3'b001, 32'h2A, 32'd0, 2, 32'h7FFF_0000, exp_rd);
        apply(v, "recover");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
